// File: rtl/scalar_operand_resolver_if.sv
// Request and result channels between decode, the operand resolver and the scalar ALU operand path.
interface scalar_operand_resolver_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_op_code;
    logic        in_literal_required;
    logic [31:0] in_literal_value;
    logic [32:0] in_fp_constant;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_value;
    logic        result_error;

    modport master (
        output in_valid, in_op_code, in_literal_required, in_literal_value, in_fp_constant,
        output result_ready,
        input  in_ready, result_valid, result_value, result_error
    );

    modport slave (
        input  in_valid, in_op_code, in_literal_required, in_literal_value, in_fp_constant,
        input  result_ready,
        output in_ready, result_valid, result_value, result_error
    );
endinterface

// File: rtl/scalar_operand_resolver.sv
// Resolves a 12-bit scalar operand code into a 32-bit value from SGPRs, live specials,
// inline constants or the literal, one request at a time.
module scalar_operand_resolver #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    scalar_operand_resolver_if.slave         bus,
    input  logic [63:0]                      vcc,
    input  logic [63:0]                      exec,
    input  logic [31:0]                      m0,
    input  logic                             scc,
    output logic                             sgpr_rd_en,
    output logic [8:0]                       sgpr_rd_addr,
    input  logic                             sgpr_rd_valid,
    input  logic [31:0]                      sgpr_rd_data
);

    typedef enum logic [1:0] {IDLE, SGPR_REQ, SGPR_WAIT, RESULT} state_t;

    typedef struct packed {
        logic        sgpr;
        logic        err;
        logic [31:0] value;
    } dec_t;

    localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    dec_t       dec;
    logic [7:0] to_cnt;
    logic       accept;
    logic       timed_out;

    function automatic dec_t resolve(
        input logic [11:0] op,
        input logic        lit_req,
        input logic [31:0] lit,
        input logic [32:0] fp,
        input logic [63:0] vcc_s,
        input logic [63:0] exec_s,
        input logic [31:0] m0_s,
        input logic        scc_s
    );
        dec_t              d;
        logic signed [9:0] imm;
        d   = '0;
        imm = op[9:0];
        if (op[11:10] == 2'b10) begin
            d.err = 1'b1;
        end else if (op[11:9] == 3'b110) begin
            d.sgpr = 1'b1;
        end else if (op[11:9] == 3'b111) begin
            case (op[8:0])
                9'd1:    d.value = vcc_s[31:0];
                9'd2:    d.value = vcc_s[63:32];
                9'd4:    d.value = m0_s;
                9'd8:    d.value = exec_s[31:0];
                9'd16:   d.value = exec_s[63:32];
                9'd32:   d.value = {31'b0, vcc_s == 64'd0};
                9'd64:   d.value = {31'b0, exec_s == 64'd0};
                9'd128:  d.value = {31'b0, scc_s};
                default: d.err   = 1'b1;
            endcase
        end else if (op[10:0] == 11'h7FF) begin
            // Remaining codes all have op[11]==0, so only the low bits need matching here.
            if (lit_req)     d.value = lit;
            else if (fp[32]) d.value = fp[31:0];
            else             d.err   = 1'b1;
        end else if (op[11:10] == 2'b00) begin
            d.value = 32'(imm);
        end else begin
            d.err = 1'b1;
        end
        return d;
    endfunction

    always_comb begin
        dec = resolve(bus.in_op_code, bus.in_literal_required, bus.in_literal_value,
                      bus.in_fp_constant, vcc, exec, m0, scc);
    end

    assign accept    = bus.in_valid && bus.in_ready;
    assign timed_out = TO_EN && !sgpr_rd_valid && (to_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.in_valid) state_next = dec.sgpr ? SGPR_REQ : RESULT;
            SGPR_REQ:  state_next = SGPR_WAIT;
            SGPR_WAIT: if (sgpr_rd_valid || timed_out) state_next = RESULT;
            RESULT:    if (bus.result_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.in_ready     = (state == IDLE) && !rst;
        bus.result_valid = (state == RESULT);
        sgpr_rd_en       = (state == SGPR_REQ);
    end

    // Result, address and timeout registers; specials are captured at accept only
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result_value <= '0;
            bus.result_error <= 1'b0;
            sgpr_rd_addr     <= '0;
            to_cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.result_value <= dec.value;
                        bus.result_error <= dec.err;
                        if (dec.sgpr) sgpr_rd_addr <= bus.in_op_code[8:0];
                    end
                end
                SGPR_REQ: to_cnt <= '0;
                SGPR_WAIT: begin
                    if (sgpr_rd_valid) begin
                        bus.result_value <= sgpr_rd_data;
                        bus.result_error <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                        if (timed_out) begin
                            bus.result_value <= '0;
                            bus.result_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_operand_resolver.sv
// Bench for scalar_operand_resolver: vector table for single-cycle decodes plus SGPR, timeout and reset sequences.
module tb_scalar_operand_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] vcc;
    logic [63:0] exec;
    logic [31:0] m0;
    logic        scc;
    logic        sgpr_rd_en;
    logic [8:0]  sgpr_rd_addr;
    logic        sgpr_rd_valid;
    logic [31:0] sgpr_rd_data;

    scalar_operand_resolver_if bus ();

    scalar_operand_resolver #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .vcc          (vcc),
        .exec         (exec),
        .m0           (m0),
        .scc          (scc),
        .sgpr_rd_en   (sgpr_rd_en),
        .sgpr_rd_addr (sgpr_rd_addr),
        .sgpr_rd_valid(sgpr_rd_valid),
        .sgpr_rd_data (sgpr_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [11:0] op;
        logic        lit_req;
        logic [31:0] lit;
        logic [32:0] fp;
        logic [63:0] vcc;
        logic [63:0] exec;
        logic [31:0] m0;
        logic        scc;
        logic [31:0] exp_v;
        logic        exp_e;
    } vec_t;

    typedef struct packed {
        logic [31:0] v;
        logic        e;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input string name, input logic [11:0] op, input logic lr, input logic [31:0] lit,
                       input logic [32:0] fp, input logic [63:0] vc, input logic [63:0] ex,
                       input logic [31:0] m, input logic s, input logic [31:0] ev, input logic ee);
        vec_t r;
        r.name = name; r.op = op; r.lit_req = lr; r.lit = lit; r.fp = fp;
        r.vcc = vc; r.exec = ex; r.m0 = m; r.scc = s; r.exp_v = ev; r.exp_e = ee;
        tbl.push_back(r);
    endtask

    // Called at a negedge; drives one request for one cycle and returns at the next negedge.
    task automatic send(input string name, input logic [11:0] op, input logic lr, input logic [31:0] lit,
                        input logic [32:0] fp, input logic push, input logic [31:0] ev, input logic ee);
        bus.in_valid            = 1'b1;
        bus.in_op_code          = op;
        bus.in_literal_required = lr;
        bus.in_literal_value    = lit;
        bus.in_fp_constant      = fp;
        #1;
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        if (push) sb.push_back('{v: ev, e: ee});
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits up to budget further cycles for result_valid, then compares against the scoreboard head.
    task automatic collect(input string name, input int budget);
        exp_t x;
        for (int i = 0; i < budget && !bus.result_valid; i++) @(negedge clk);
        if (!bus.result_valid) begin
            check({name, "_result_valid"}, 64'd0, 64'd1);
        end else if (sb.size() == 0) begin
            check({name, "_unexpected_result"}, 64'd1, 64'd0);
        end else begin
            x = sb.pop_front();
            check({name, "_value"}, 64'(bus.result_value), 64'(x.v));
            check({name, "_error"}, 64'(bus.result_error), 64'(x.e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;

        add("int_64",     12'h040, 0, 0, 33'd0, 0, 0, 0, 0, 32'h0000_0040, 0);
        add("int_m16",    12'h3F0, 0, 0, 33'd0, 0, 0, 0, 0, 32'hFFFF_FFF0, 0);
        add("int_m63",    12'h3C1, 0, 0, 33'd0, 0, 0, 0, 0, 32'hFFFF_FFC1, 0);
        add("fp_const",   12'h7FF, 0, 32'h1111_1111, {1'b1, 32'hBF80_0000}, 0, 0, 0, 0, 32'hBF80_0000, 0);
        add("literal",    12'h7FF, 1, 32'hDEAD_BEEF, {1'b1, 32'hBF80_0000}, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
        add("no_literal", 12'h7FF, 0, 32'hDEAD_BEEF, {1'b0, 32'hBF80_0000}, 0, 0, 0, 0, 32'h0, 1);
        add("vgpr",       12'h805, 0, 0, 33'd0, 0, 0, 0, 0, 32'h0, 1);
        add("reserved01", 12'h400, 0, 0, 33'd0, 0, 0, 0, 0, 32'h0, 1);
        add("vccz",       12'hE20, 0, 0, 33'd0, 64'h0, 64'h1_0000_0000, 0, 0, 32'h1, 0);
        add("execz",      12'hE40, 0, 0, 33'd0, 64'h0, 64'h1_0000_0000, 0, 0, 32'h0, 0);
        add("exec_hi",    12'hE10, 0, 0, 33'd0, 64'h0, 64'h1_0000_0000, 0, 0, 32'h1, 0);
        add("vcc_lo",     12'hE01, 0, 0, 33'd0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, 32'hCCCC_DDDD, 0);
        add("vcc_hi",     12'hE02, 0, 0, 33'd0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, 32'hAAAA_BBBB, 0);
        add("m0",         12'hE04, 0, 0, 33'd0, 0, 0, 32'h0000_1357, 0, 32'h0000_1357, 0);
        add("exec_lo",    12'hE08, 0, 0, 33'd0, 0, 64'h1111_2222_3333_4444, 0, 0, 32'h3333_4444, 0);
        add("scc",        12'hE80, 0, 0, 33'd0, 64'h5, 64'h5, 0, 1, 32'h1, 0);
        add("special_3",  12'hE03, 0, 0, 33'd0, 64'h5, 64'h5, 0, 0, 32'h0, 1);
        add("special_0",  12'hE00, 0, 0, 33'd0, 64'h5, 64'h5, 0, 0, 32'h0, 1);

        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_op_code = 12'h040; bus.in_literal_required = 1'b0;
        bus.in_literal_value = '0; bus.in_fp_constant = '0; bus.result_ready = 1'b1;
        vcc = '0; exec = '0; m0 = '0; scc = 1'b0; sgpr_rd_valid = 1'b0; sgpr_rd_data = '0;

        // Reset held three cycles with a request pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", 64'(bus.in_ready), 64'd0);
            check("rst_result_valid", 64'(bus.result_valid), 64'd0);
            check("rst_sgpr_rd_en", 64'(sgpr_rd_en), 64'd0);
        end
        check("rst_result_value", 64'(bus.result_value), 64'd0);
        check("rst_sgpr_rd_addr", 64'(sgpr_rd_addr), 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Single-cycle decodes, consumed immediately
        foreach (tbl[i]) begin
            vcc = tbl[i].vcc; exec = tbl[i].exec; m0 = tbl[i].m0; scc = tbl[i].scc;
            send(tbl[i].name, tbl[i].op, tbl[i].lit_req, tbl[i].lit, tbl[i].fp, 1'b1,
                 tbl[i].exp_v, tbl[i].exp_e);
            collect(tbl[i].name, 0);
            @(negedge clk);
            check({tbl[i].name, "_consumed"}, 64'(bus.result_valid), 64'd0);
            check({tbl[i].name, "_ready_again"}, 64'(bus.in_ready), 64'd1);
        end

        // Specials are captured at accept; later changes must not leak into a held result
        bus.result_ready = 1'b0;
        vcc = 64'h0123_4567_89AB_CDEF;
        send("hold_vcc", 12'hE01, 0, 0, 33'd0, 1'b1, 32'h89AB_CDEF, 1'b0);
        vcc = 64'hFFFF_FFFF_FFFF_FFFF;
        collect("hold_vcc", 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_vcc_stable", 64'(bus.result_value), 64'h89AB_CDEF);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // SGPR read, response three cycles after the strobe, then held unconsumed
        bus.result_ready = 1'b0;
        send("sgpr5", 12'hC05, 0, 0, 33'd0, 1'b1, 32'h1234_5678, 1'b0);
        check("sgpr5_rd_en", 64'(sgpr_rd_en), 64'd1);
        check("sgpr5_rd_addr", 64'(sgpr_rd_addr), 64'd5);
        @(negedge clk);
        check("sgpr5_rd_en_once", 64'(sgpr_rd_en), 64'd0);
        check("sgpr5_not_early", 64'(bus.result_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        sgpr_rd_valid = 1'b1; sgpr_rd_data = 32'h1234_5678;
        @(negedge clk);
        sgpr_rd_valid = 1'b0; sgpr_rd_data = 32'h0BAD_0BAD;
        collect("sgpr5", 0);
        held = bus.result_value;
        for (int i = 0; i < 4; i++) begin
            sgpr_rd_valid = (i == 1);
            @(negedge clk);
            check("sgpr5_hold_value", 64'(bus.result_value), 64'h1234_5678);
            check("sgpr5_hold_valid", 64'(bus.result_valid), 64'd1);
            check("sgpr5_hold_addr", 64'(sgpr_rd_addr), 64'd5);
        end
        sgpr_rd_valid = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        check("sgpr5_released", 64'(bus.in_ready), 64'd1);

        // SGPR timeout after four wait cycles; a late response is dropped
        send("sgpr_to", 12'hC07, 0, 0, 33'd0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sgpr_to_waiting", 64'(bus.result_valid), 64'd0);
        end
        @(negedge clk);
        collect("sgpr_to", 0);
        @(negedge clk);
        sgpr_rd_valid = 1'b1; sgpr_rd_data = 32'hCAFE_F00D;
        #1;
        check("sgpr_to_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        sgpr_rd_valid = 1'b0;
        check("sgpr_to_late_dropped", 64'(bus.result_valid), 64'd0);
        check("sgpr_to_no_strobe", 64'(sgpr_rd_en), 64'd0);

        // Reset during SGPR_WAIT discards the request; the late response yields nothing
        send("sgpr_rst", 12'hC09, 0, 0, 33'd0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("sgpr_rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("sgpr_rst_idle", 64'(bus.in_ready), 64'd1);
        check("sgpr_rst_no_result", 64'(bus.result_valid), 64'd0);
        sgpr_rd_valid = 1'b1; sgpr_rd_data = 32'h7777_7777;
        @(negedge clk);
        sgpr_rd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("sgpr_rst_late_dropped", 64'(bus.result_valid), 64'd0);
            check("sgpr_rst_no_strobe", 64'(sgpr_rd_en), 64'd0);
            @(negedge clk);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
